// File: rtl/hyperbus_arbiter.sv
// ============================================================================
//  Module      : hyperbus_arbiter
//  Description : Round-robin arbiter sharing one hyperbus controller core
//                between NPORTS requesters, one 16-bit word per transaction,
//                with a watchdog that aborts transactions the core never
//                completes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hyperbus_arbiter #(
    parameter int NPORTS  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORTS-1:0]      m_req,
    input  logic [NPORTS-1:0]      m_we,
    input  logic [NPORTS-1:0]      m_reg_space,
    input  logic [32*NPORTS-1:0]   m_adr,
    input  logic [16*NPORTS-1:0]   m_dat_i,
    output logic [15:0]            m_dat_o,
    output logic [NPORTS-1:0]      m_ack,
    output logic [NPORTS-1:0]      m_err,
    output logic [31:0]            hbus_adr_o,
    output logic [15:0]            hbus_dat_o,
    input  logic [15:0]            hbus_dat_i,
    output logic                   hbus_reg_space,
    output logic                   hbus_rrq,
    output logic                   hbus_wrq,
    input  logic                   hbus_ready,
    input  logic                   hbus_valid,
    input  logic                   hbus_busy,
    output logic [NPORTS-1:0]      grant_o
);

    localparam int            PW         = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int            TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gidx;
    logic            we_q;
    logic [TW-1:0]   timer;
    logic [1:0]      wait_cnt;

    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   cand;
    logic            pick_found;
    logic [PW-1:0]   rr_next;
    logic            timed_out;
    logic            rd_done;
    logic            wr_done;
    int              j;

    // Pick the first requesting port at or after the round-robin pointer.
    always_comb begin
        pick_idx   = '0;
        cand       = '0;
        pick_found = 1'b0;
        j          = 0;
        for (int i = 0; i < NPORTS; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NPORTS) begin
                j = j - NPORTS;
            end
            cand = PW'(j);
            if (!pick_found && m_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Pointer value after the current owner finishes, and completion terms.
    always_comb begin
        rr_next   = (int'(gidx) == NPORTS - 1) ? '0 : gidx + PW'(1);
        timed_out = (timer == TIMER_LAST);
        rd_done   = !we_q && hbus_valid;
        // Ready is only trusted two cycles after the strobe so a stale
        // ready from before the core picked up the request is ignored.
        wr_done   = we_q && (wait_cnt == 2'd2) && hbus_ready && !hbus_busy;
    end

    // Transaction state machine with registered core and client outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            gidx           <= '0;
            we_q           <= 1'b0;
            timer          <= '0;
            wait_cnt       <= '0;
            m_dat_o        <= '0;
            m_ack          <= '0;
            m_err          <= '0;
            hbus_adr_o     <= '0;
            hbus_dat_o     <= '0;
            hbus_reg_space <= 1'b0;
            hbus_rrq       <= 1'b0;
            hbus_wrq       <= 1'b0;
            grant_o        <= '0;
        end else begin
            m_ack    <= '0;
            m_err    <= '0;
            hbus_rrq <= 1'b0;
            hbus_wrq <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gidx           <= pick_idx;
                        we_q           <= m_we[pick_idx];
                        hbus_adr_o     <= m_adr[32*pick_idx +: 32];
                        hbus_dat_o     <= m_dat_i[16*pick_idx +: 16];
                        hbus_reg_space <= m_reg_space[pick_idx];
                        grant_o        <= NPORTS'(1) << pick_idx;
                        timer          <= '0;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= timer + TW'(1);
                    if (timed_out) begin
                        m_err          <= grant_o;
                        rr_ptr         <= rr_next;
                        grant_o        <= '0;
                        hbus_adr_o     <= '0;
                        hbus_dat_o     <= '0;
                        hbus_reg_space <= 1'b0;
                        state          <= IDLE;
                    end else if (hbus_ready) begin
                        hbus_rrq <= !we_q;
                        hbus_wrq <= we_q;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    if (wait_cnt != 2'd2) begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                    if (rd_done) begin
                        m_dat_o <= hbus_dat_i;
                        m_ack   <= grant_o;
                        state   <= DONE;
                    end else if (wr_done) begin
                        m_ack <= grant_o;
                        state <= DONE;
                    end else if (timed_out) begin
                        m_err          <= grant_o;
                        rr_ptr         <= rr_next;
                        grant_o        <= '0;
                        hbus_adr_o     <= '0;
                        hbus_dat_o     <= '0;
                        hbus_reg_space <= 1'b0;
                        state          <= IDLE;
                    end
                end
                DONE: begin
                    rr_ptr         <= rr_next;
                    grant_o        <= '0;
                    hbus_adr_o     <= '0;
                    hbus_dat_o     <= '0;
                    hbus_reg_space <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
